hazard_ctrl: RTL and testbench

Parametrised hazard detection and forwarding controller for the in-order processor pipeline. It sits beside the IF_ID/ID_EX/EX_MEM/MEM_WB registers and tracks every in-flight destination register in a shadow pipeline of configurable depth. From that record it generates the front-end stall, per-operand forwarding selects and a stall-cycle counter. It generalises the fixed 5-stage datapath to any EX-to-WB depth, with configurable load latency.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall and operand forwarding selects.
// Optional forwarding network: define HAZARD_FWD_EN to enable it.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16,
   parameter int SEL_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rd_we,
   input  logic                  id_is_load,
   input  logic                  flush,
   output logic                  stall,
   output logic                  issue,
   output logic [SEL_W-1:0]      fwd_rs1_sel,
   output logic [SEL_W-1:0]      fwd_rs2_sel,
   output logic [DEPTH-1:0]      inflight,
   output logic [CNT_W-1:0]      stall_count
);

   logic [DEPTH-1:0]      r_vld;
   logic [DEPTH-1:0]      r_ld;
   logic [REG_ADDR_W-1:0] r_rd [DEPTH];
   logic [CNT_W-1:0]      r_cnt;

   logic [DEPTH-1:0]      w_m1;
   logic [DEPTH-1:0]      w_m2;
   logic                  w_ldhaz;
   logic                  w_hazard;
   logic                  w_stall;
   logic                  w_issue;
   logic                  w_new_vld;

   // Youngest match decides: a younger non-load producer hides an older load.
   function automatic logic f_ldhaz(
      input logic [DEPTH-1:0] m,
      input logic [DEPTH-1:0] ld
   );
      logic r;
      r = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m[i]) begin
            r = ld[i] && (i < LOAD_LAT);
         end
      end
      return r;
   endfunction

`ifdef HAZARD_FWD_EN
   // Select value is youngest matching index plus one, 0 when no match.
   function automatic logic [SEL_W-1:0] f_sel(
      input logic [DEPTH-1:0] m
   );
      logic [SEL_W-1:0] s;
      s = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m[i]) begin
            s = SEL_W'(i + 1);
         end
      end
      return s;
   endfunction
`endif

   // Per-entry RAW match for each source operand; x0 never matches.
   always_comb begin
      w_m1 = '0;
      w_m2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_m1[i] = id_rs1_used && (id_rs1 != '0) &&
                   r_vld[i] && (r_rd[i] == id_rs1);
         w_m2[i] = id_rs2_used && (id_rs2 != '0) &&
                   r_vld[i] && (r_rd[i] == id_rs2);
      end
   end

   assign w_ldhaz = f_ldhaz(w_m1, r_ld) | f_ldhaz(w_m2, r_ld);

`ifdef HAZARD_FWD_EN
   assign w_hazard    = w_ldhaz;
   assign fwd_rs1_sel = f_sel(w_m1);
   assign fwd_rs2_sel = f_sel(w_m2);
`else
   // Any match short of WB stalls; WB is covered by register-file
   // write-through. A load-use match always lies inside that window.
   assign w_hazard    = w_ldhaz |
                        (|w_m1[DEPTH-2:0]) |
                        (|w_m2[DEPTH-2:0]);
   assign fwd_rs1_sel = '0;
   assign fwd_rs2_sel = '0;
`endif

   assign w_stall   = id_valid & w_hazard & ~flush;
   assign w_issue   = id_valid & ~w_stall & ~flush;
   assign w_new_vld = w_issue & id_rd_we & (id_rd != '0);

   // Shift the shadow pipeline; entry 0 takes the issued op or a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld <= '0;
         r_ld  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i] <= '0;
         end
      end else begin
         r_vld   <= {r_vld[DEPTH-2:0], w_new_vld};
         r_ld    <= {r_ld[DEPTH-2:0], w_new_vld & id_is_load};
         r_rd[0] <= id_rd;
         for (int i = 1; i < DEPTH; i++) begin
            r_rd[i] <= r_rd[i-1];
         end
      end
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign stall       = w_stall;
   assign issue       = w_issue;
   assign inflight    = r_vld;
   assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, corner sequences and random stimulus
// against an age-based model of the in-flight producers.
module tb_hazard_ctrl;

   localparam int RW       = 5;
   localparam int DEPTH    = 3;
   localparam int LOAD_LAT = 1;
   localparam int CNT_W    = 16;
   localparam int SEL_W    = $clog2(DEPTH + 1);
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             id_valid;
   logic [RW-1:0]    id_rs1, id_rs2, id_rd;
   logic             id_rs1_used, id_rs2_used;
   logic             id_rd_we, id_is_load, flush;
   logic             stall, issue;
   logic [SEL_W-1:0] fwd_rs1_sel, fwd_rs2_sel;
   logic [DEPTH-1:0] inflight;
   logic [CNT_W-1:0] stall_count;

   hazard_ctrl #(
      .REG_ADDR_W (RW),
      .DEPTH      (DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_rd       (id_rd),
      .id_rd_we    (id_rd_we),
      .id_is_load  (id_is_load),
      .flush       (flush),
      .stall       (stall),
      .issue       (issue),
      .fwd_rs1_sel (fwd_rs1_sel),
      .fwd_rs2_sel (fwd_rs2_sel),
      .inflight    (inflight),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic v;
      logic [RW-1:0] rs1, rs2;
      logic u1, u2;
      logic [RW-1:0] rd;
      logic we, ld, fl;
      logic st, is;
      int s1, s2;
      logic [DEPTH-1:0] inf;
      int cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic v, input int rs1, input int rs2,
      input logic u1, input logic u2, input int rd,
      input logic we, input logic ld, input logic fl,
      input logic st, input logic is, input int s1, input int s2,
      input logic [DEPTH-1:0] inf, input int cnt);
      vec_t r;
      r.v = v; r.rs1 = RW'(rs1); r.rs2 = RW'(rs2);
      r.u1 = u1; r.u2 = u2; r.rd = RW'(rd);
      r.we = we; r.ld = ld; r.fl = fl;
      r.st = st; r.is = is; r.s1 = s1; r.s2 = s2;
      r.inf = inf; r.cnt = cnt;
      return r;
   endfunction

   // Model: list of producers still in flight, each with its age in cycles.
   typedef struct {
      int age;
      logic [RW-1:0] rd;
      bit ld;
   } prod_t;

   prod_t q[$];
   int m_cnt;

   function automatic void m_find(input logic [RW-1:0] rs, input logic used,
                                  output int age, output bit ld);
      age = -1;
      ld  = 1'b0;
      if (used && rs != 0) begin
         foreach (q[j]) begin
            if (q[j].rd == rs && (age < 0 || q[j].age < age)) begin
               age = q[j].age;
               ld  = q[j].ld;
            end
         end
      end
   endfunction

   function automatic bit m_haz(input int age, input bit ld);
      if (age < 0) return 1'b0;
      if (FWD) return ld && (age < LOAD_LAT);
      return age <= DEPTH - 2;
   endfunction

   function automatic void m_eval(output bit st, output bit is,
                                  output int s1, output int s2,
                                  output logic [DEPTH-1:0] inf);
      int a1, a2;
      bit l1, l2;
      m_find(id_rs1, id_rs1_used, a1, l1);
      m_find(id_rs2, id_rs2_used, a2, l2);
      st = id_valid && (m_haz(a1, l1) || m_haz(a2, l2)) && !flush;
      is = id_valid && !st && !flush;
      s1 = (FWD && a1 >= 0) ? a1 + 1 : 0;
      s2 = (FWD && a2 >= 0) ? a2 + 1 : 0;
      inf = '0;
      foreach (q[j]) inf[q[j].age] = 1'b1;
   endfunction

   function automatic void m_advance();
      bit st, is;
      int s1, s2;
      logic [DEPTH-1:0] inf;
      m_eval(st, is, s1, s2, inf);
      foreach (q[j]) q[j].age++;
      for (int j = q.size() - 1; j >= 0; j--) begin
         if (q[j].age >= DEPTH) q.delete(j);
      end
      if (is && id_rd_we && id_rd != 0)
         q.push_back('{age: 0, rd: id_rd, ld: id_is_load});
      if (st && m_cnt < CNT_MAX) m_cnt++;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      bit st, is;
      int s1, s2;
      logic [DEPTH-1:0] inf;
      m_eval(st, is, s1, s2, inf);
      chk({tag, " stall"}, 32'(stall), 32'(st));
      chk({tag, " issue"}, 32'(issue), 32'(is));
      chk({tag, " sel1"}, 32'(fwd_rs1_sel), 32'(s1));
      chk({tag, " sel2"}, 32'(fwd_rs2_sel), 32'(s2));
      chk({tag, " infl"}, 32'(inflight), 32'(inf));
      chk({tag, " cnt"}, 32'(stall_count), 32'(m_cnt));
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.v; id_rs1 = v.rs1; id_rs2 = v.rs2;
      id_rs1_used = v.u1; id_rs2_used = v.u2;
      id_rd = v.rd; id_rd_we = v.we; id_is_load = v.ld;
      flush = v.fl;
   endtask

   task automatic idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0));
   endtask

   task automatic step();
      @(posedge clk);
      m_advance();
      #1;
   endtask

   initial begin
      string nm;
      reset = 1'b1;
      idle();
      q.delete();
      m_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst infl", 32'(inflight), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst issue", 32'(issue), 32'd0);
      chk("rst sel1", 32'(fwd_rs1_sel), 32'd0);
      chk("rst cnt", 32'(stall_count), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

`ifdef HAZARD_FWD_EN
      tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0, 3'b000, 0));
      tbl.push_back(mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 0, 1, 1, 0, 3'b001, 0));
      tbl.push_back(mk(1, 5, 3, 1, 1, 10, 1, 0, 0, 0, 1, 2, 0, 3'b011, 0));
      tbl.push_back(mk(1, 2, 0, 1, 0, 6, 1, 1, 0, 0, 1, 0, 0, 3'b111, 0));
      tbl.push_back(mk(1, 2, 6, 1, 1, 8, 1, 0, 0, 1, 0, 0, 1, 3'b111, 0));
      tbl.push_back(mk(1, 2, 6, 1, 1, 8, 1, 0, 0, 0, 1, 0, 2, 3'b110, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b101, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3'b000, 1));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
`else
      tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0, 3'b000, 0));
      tbl.push_back(mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0, 3'b001, 0));
      tbl.push_back(mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0, 3'b010, 1));
      tbl.push_back(mk(1, 5, 1, 1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 3'b100, 2));
      tbl.push_back(mk(1, 3, 4, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 3'b001, 2));
      tbl.push_back(mk(1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 3'b010, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2));
`endif

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         nm = $sformatf("t%0d", i);
         chk({nm, " stall"}, 32'(stall), 32'(tbl[i].st));
         chk({nm, " issue"}, 32'(issue), 32'(tbl[i].is));
         chk({nm, " sel1"}, 32'(fwd_rs1_sel), 32'(tbl[i].s1));
         chk({nm, " sel2"}, 32'(fwd_rs2_sel), 32'(tbl[i].s2));
         chk({nm, " infl"}, 32'(inflight), 32'(tbl[i].inf));
         chk({nm, " cnt"}, 32'(stall_count), 32'(tbl[i].cnt));
         step();
      end

      // Reset arriving in the middle of a stall.
      drive(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, '0, 0));
      step();
      drive(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, '0, 0));
      step();
      drive(mk(1, 9, 0, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0, '0, 0));
      @(negedge clk);
      chk("mid stall", 32'(stall), 32'd1);
      chk("mid infl", 32'(inflight), 32'b011);
      #2;
      reset = 1'b1;
      idle();
      #1;
      q.delete();
      m_cnt = 0;
      chk("arst infl", 32'(inflight), 32'd0);
      chk("arst stall", 32'(stall), 32'd0);
      chk("arst issue", 32'(issue), 32'd0);
      chk("arst sel", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'd0);
      chk("arst cnt", 32'(stall_count), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      drive(mk(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, '0, 0));
      @(negedge clk);
      chk("post stall", 32'(stall), 32'd0);
      chk("post issue", 32'(issue), 32'd1);
      step();

      // Load-use hazard killed by a same-cycle flush.
      drive(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, '0, 0));
      @(negedge clk);
      chk("lw issue", 32'(issue), 32'd1);
      step();
      drive(mk(1, 2, 6, 1, 1, 8, 1, 0, 1, 0, 0, 0, 0, '0, 0));
      @(negedge clk);
      chk("fl stall", 32'(stall), 32'd0);
      chk("fl issue", 32'(issue), 32'd0);
      step();
      idle();
      @(negedge clk);
      chk("fl bit0", 32'(inflight[0]), 32'd0);
      chk("fl cnt", 32'(stall_count), 32'(m_cnt));
      step();

      for (int n = 0; n < 1500; n++) begin
         id_valid    = ($urandom_range(0, 9) < 8);
         id_rs1      = RW'($urandom_range(0, 7));
         id_rs2      = RW'($urandom_range(0, 7));
         id_rs1_used = ($urandom_range(0, 3) != 0);
         id_rs2_used = ($urandom_range(0, 3) != 0);
         id_rd       = RW'($urandom_range(0, 7));
         id_rd_we    = ($urandom_range(0, 4) != 0);
         id_is_load  = ($urandom_range(0, 9) < 3);
         flush       = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         chk_model("rnd");
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
